// File: rtl/rr_agent_requester.sv
`timescale 1ns/1ps
// Requester endpoint for the round-robin arbiter: buffers producer beats in a FIFO and
// streams each complete packet onto the shared bus while granted, marking the final beat with eot.
module rr_agent_requester #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              req,
    input  logic              gnt,
    output logic              eot,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              busy,
    output logic              pkt_err,
    output logic [1:0]        state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  mem_last;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     pkt_cnt;
    logic              discard;
    logic              full;
    logic              overflow;
    logic              head_last;
    logic              accept;
    logic              push;
    logic              pop;

    // Handshakes: a producer beat transfers on a rising edge with wr_valid && wr_ready;
    // a bus beat transfers on every rising edge where bus_valid is high (no back-pressure).
    assign full      = (count == CW'(DEPTH));
    assign overflow  = full && (pkt_cnt == '0);
    assign head_last = mem_last[rd_ptr];
    assign bus_data  = mem_data[rd_ptr];
    assign pop       = bus_valid;
    assign wr_ready  = !rst && (!full || pop);
    assign accept    = wr_valid && wr_ready;
    assign push      = accept && !discard;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= wr_data;
            mem_last[wr_ptr] <= wr_last;
        end
    end

    // An oversize packet is flushed and its tail swallowed up to and including its last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            pkt_err <= 1'b0;
            discard <= 1'b0;
        end else if (overflow) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            pkt_err <= 1'b1;
            discard <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            case ({push && wr_last, pop && head_last})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
            if (discard && accept && wr_last) discard <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // GAP gives the arbiter exactly one low-req cycle before a queued packet re-requests.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pkt_cnt != '0) state_nxt = S_REQ;
            S_REQ:   if (eot) state_nxt = S_GAP;
            S_GAP:   state_nxt = (pkt_cnt != '0) ? S_REQ : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req       = (state == S_REQ);
        bus_valid = req && gnt;
        eot       = bus_valid && head_last;
        busy      = (state != S_IDLE);
        state_dbg = state;
    end
endmodule

// File: tb/tb_rr_agent_requester.sv
`timescale 1ns/1ps
// Directed bench for rr_agent_requester: hand-built packets, a delayed-req grant source
// and a bus-side scoreboard holding the expected {last, data} sequence.
module tb_rr_agent_requester;
    localparam int DATA_W = 8;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              wr_valid = 1'b0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              wr_last  = 1'b0;
    logic              gnt      = 1'b0;
    logic              wr_ready;
    logic              req;
    logic              eot;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              busy;
    logic              pkt_err;
    logic [1:0]        state_dbg;

    logic              gnt_en   = 1'b0;
    logic              gnt_hold = 1'b0;
    logic              req_s    = 1'b0;
    int                n_vec      = 0;
    int                n_err      = 0;
    int                eot_count  = 0;
    int                req_cycles = 0;
    int                eot0;
    int                req0;
    int                plen [10] = '{1, 2, 3, 4, 1, 3, 2, 4, 1, 2};
    logic [DATA_W:0]   exp_q [$];

    rr_agent_requester #(.DATA_W(DATA_W), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .req       (req),
        .gnt       (gnt),
        .eot       (eot),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .busy      (busy),
        .pkt_err   (pkt_err),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // grant source: gnt follows req one cycle late, like the arbiter
    initial begin
        forever begin
            @(negedge clk);
            req_s = req;
            @(posedge clk);
            #2;
            gnt = gnt_en && req_s && !gnt_hold;
        end
    end

    // scoreboard on the shared bus
    initial begin
        forever begin
            @(negedge clk);
            if (req) req_cycles++;
            if (eot) begin
                eot_count++;
                check("eot_has_valid", bus_valid, 1);
            end
            if (bus_valid) begin
                if (exp_q.size() == 0) check("bus_extra_beat", bus_valid, 0);
                else                   check("bus_beat", {eot, bus_data}, exp_q.pop_front());
            end
        end
    end

    // driver tasks (called just after a rising edge)
    task automatic push_beat(input logic [DATA_W-1:0] d, input logic l, input bit keep);
        bit took = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = wr_ready;
        end
        if (!took) check("push_timeout", took, 1);
        if (keep && took) exp_q.push_back({l, d});
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = req;
        end
        check(tag, seen, 1);
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
        end
        check(tag, done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        repeat (1) @(posedge clk);
        @(negedge clk);
        check("rst_wr_ready", wr_ready, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_req", req, 0);
        check("rst_eot", eot, 0);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_err", pkt_err, 0);
        check("rst_wr_ready_hi", wr_ready, 1);
        check("rst_count", dut.count, 0);
        @(posedge clk); #1;
        gnt_en = 1'b1;

        // 1) single 3-beat packet
        push_beat(8'hA1, 1'b0, 1'b1);
        push_beat(8'hB2, 1'b0, 1'b1);
        push_beat(8'hC3, 1'b1, 1'b1);
        @(negedge clk); check("t1_req_wait", req, 0); check("t1_pkt_cnt", dut.pkt_cnt, 1);
        @(negedge clk); check("t1_req_rise", req, 1); check("t1_bv_nognt", bus_valid, 0);
        @(negedge clk); check("t1_beatA", {bus_valid, eot, bus_data}, {2'b10, 8'hA1});
        @(negedge clk); check("t1_beatB", {bus_valid, eot, bus_data}, {2'b10, 8'hB2});
        @(negedge clk); check("t1_beatC", {bus_valid, eot, bus_data}, {2'b11, 8'hC3});
        @(negedge clk); check("t1_gap_req", req, 0); check("t1_gap_bv", bus_valid, 0);
        check("t1_gap_busy", busy, 1); check("t1_gap_state", state_dbg, 2);
        @(negedge clk); check("t1_idle_busy", busy, 0);
        @(posedge clk); #1;

        // 2) two 2-beat packets back-to-back
        push_beat(8'h11, 1'b0, 1'b1);
        push_beat(8'h12, 1'b1, 1'b1);
        push_beat(8'h21, 1'b0, 1'b1);
        push_beat(8'h22, 1'b1, 1'b1);
        @(negedge clk); check("t2_c4_bv", bus_valid, 1); check("t2_c4_eot", eot, 0);
        check("t2_c4_pkt_cnt", dut.pkt_cnt, 2);
        @(negedge clk); check("t2_eot1", eot, 1); check("t2_eot1_pkt_cnt", dut.pkt_cnt, 2);
        @(negedge clk); check("t2_gap_req", req, 0); check("t2_gap_pkt_cnt", dut.pkt_cnt, 1);
        @(negedge clk); check("t2_req2", req, 1); check("t2_req2_bv", bus_valid, 0);
        @(negedge clk); check("t2_p2a", {bus_valid, eot}, 2'b10);
        @(negedge clk); check("t2_eot2", eot, 1);
        @(negedge clk); check("t2_end_req", req, 0); check("t2_end_pkt_cnt", dut.pkt_cnt, 0);
        @(negedge clk); check("t2_end_busy", busy, 0); check("t2_sb_empty", exp_q.size(), 0);
        @(posedge clk); #1;

        // 3) full FIFO with simultaneous push/pop, then pointer wrap over 10 packets
        eot0 = eot_count;
        gnt_en = 1'b0;
        push_beat(8'h40, 1'b0, 1'b1);
        push_beat(8'h41, 1'b0, 1'b1);
        push_beat(8'h42, 1'b0, 1'b1);
        push_beat(8'h43, 1'b1, 1'b1);
        @(negedge clk); check("t3_full_count", dut.count, 4); check("t3_full_ready", wr_ready, 0);
        wait_req("t3_req");
        @(posedge clk); #1;
        gnt_en = 1'b1;
        wr_valid = 1'b1; wr_data = 8'h50; wr_last = 1'b0;
        exp_q.push_back({1'b0, 8'h50});
        @(negedge clk); check("t3_pp_ready", wr_ready, 1); check("t3_pp_count", dut.count, 4);
        @(posedge clk); #1;
        wr_data = 8'h51;
        exp_q.push_back({1'b0, 8'h51});
        @(negedge clk); check("t3_pp_ready2", wr_ready, 1); check("t3_pp_count2", dut.count, 4);
        @(posedge clk); #1;
        push_beat(8'h52, 1'b0, 1'b1);
        push_beat(8'h53, 1'b1, 1'b1);
        for (int p = 0; p < 10; p++) begin
            for (int b = 0; b < plen[p]; b++) begin
                push_beat(DATA_W'(8'h60 + p * 8 + b), (b == plen[p] - 1), 1'b1);
            end
        end
        drain("t3_drain");
        check("t3_eot_total", eot_count - eot0, 12);

        // 4) grant withdrawn for two cycles mid-packet
        eot0 = eot_count;
        push_beat(8'hD0, 1'b0, 1'b1);
        push_beat(8'hD1, 1'b0, 1'b1);
        push_beat(8'hD2, 1'b0, 1'b1);
        push_beat(8'hD3, 1'b1, 1'b1);
        wait_req("t4_req");
        @(posedge clk); #1;
        @(negedge clk); check("t4_first", {bus_valid, bus_data}, {1'b1, 8'hD0});
        @(posedge clk); #1; gnt_hold = 1'b1;
        @(negedge clk); check("t4_hold1", {req, bus_valid, bus_data}, {2'b10, 8'hD1});
        @(posedge clk); #1;
        @(negedge clk); check("t4_hold2", {req, bus_valid, bus_data}, {2'b10, 8'hD1});
        @(posedge clk); #1; gnt_hold = 1'b0;
        drain("t4_drain");
        check("t4_eot_once", eot_count - eot0, 1);

        // 5) oversize packet, then a normal one
        eot0 = eot_count;
        req0 = req_cycles;
        push_beat(8'hE0, 1'b0, 1'b0);
        push_beat(8'hE1, 1'b0, 1'b0);
        push_beat(8'hE2, 1'b0, 1'b0);
        push_beat(8'hE3, 1'b0, 1'b0);
        push_beat(8'hE4, 1'b1, 1'b0);
        @(negedge clk);
        check("t5_pkt_err", pkt_err, 1);
        check("t5_count", dut.count, 0);
        check("t5_pkt_cnt", dut.pkt_cnt, 0);
        repeat (4) @(negedge clk);
        check("t5_no_req", req_cycles - req0, 0);
        @(posedge clk); #1;
        push_beat(8'hF0, 1'b0, 1'b1);
        push_beat(8'hF1, 1'b1, 1'b1);
        drain("t5_drain");
        check("t5_eot_once", eot_count - eot0, 1);
        check("t5_err_sticky", pkt_err, 1);

        // 6) reset mid-packet
        eot0 = eot_count;
        push_beat(8'h90, 1'b0, 1'b1);
        push_beat(8'h91, 1'b0, 1'b1);
        push_beat(8'h92, 1'b0, 1'b1);
        push_beat(8'h93, 1'b1, 1'b1);
        wait_req("t6_req");
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_req", req, 0);
        check("t6_bv", bus_valid, 0);
        check("t6_eot", eot, 0);
        check("t6_busy", busy, 0);
        check("t6_count", dut.count, 0);
        check("t6_pkt_err", pkt_err, 0);
        check("t6_wr_ready", wr_ready, 1);
        repeat (6) @(negedge clk);
        check("t6_no_eot", eot_count - eot0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
